// File: rtl/i2c_write_master.sv
// I2C write-only master: START, 7-bit address + W, NUM_BYTES data bytes with
// ACK checks, then STOP. SCL is push-pull, SDA is open-drain via sda_oe.
module i2c_write_master #(
    parameter int CLK_DIV   = 4,
    parameter int NUM_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [6:0]             dev_addr,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   sda_in,
    output logic                   scl,
    output logic                   sda_oe,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_ADDR, ST_ACK, ST_DATA, ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             qtr_q, qtr_d;
    logic [2:0]             bit_q, bit_d;
    logic [BW-1:0]          byte_q, byte_d;
    logic [7:0]             shift_q, shift_d;
    logic [6:0]             addr_q, addr_d;
    logic [8*NUM_BYTES-1:0] data_q, data_d;
    logic                   scl_q, scl_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ack_err_q, ack_err_d;

    logic cnt_end, slot_end;
    assign cnt_end  = (cnt_q == CW'(CLK_DIV - 1));
    assign slot_end = cnt_end && (qtr_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;

        if (state_q != ST_IDLE) begin
            if (cnt_end) begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = dev_addr;
                    data_d    = data;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_ADDR;
                    shift_d = {addr_q, 1'b0};
                    bit_d   = '0;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        state_d = ST_ACK;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_ACK: begin
                // Sample in the middle of SCL high, well clear of both edges.
                if (qtr_q == 2'd2 && cnt_end && sda_in) ack_err_d = 1'b1;
                if (slot_end) begin
                    // ack_err_q here can only come from this slot: any NACK aborts.
                    if (ack_err_q || byte_q == BW'(NUM_BYTES)) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                        byte_d  = byte_q + BW'(1);
                        shift_d = data_q[8*NUM_BYTES-1 -: 8];
                        data_d  = data_q << 8;
                    end
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    byte_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next position so they line up with the registered state.
        case (state_d)
            ST_START: begin
                scl_d    = 1'b1;
                sda_oe_d = qtr_d[1];
            end
            ST_ADDR, ST_DATA: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~shift_d[7];
            end
            ST_ACK: begin
                scl_d    = qtr_d[1];
                sda_oe_d = 1'b0;
            end
            ST_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = ~qtr_d[1];
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: default instance (CLK_DIV=4, 2 bytes) and a
// CLK_DIV=1, 3-byte instance, with a bus-level slave model and byte scoreboard.
module tb_i2c_write_master;
    logic        clk;
    logic        reset;
    logic        start_w   [2];
    logic [6:0]  dev_addr;
    logic [23:0] data_v;
    logic        sda_in_w  [2];
    logic        scl_w     [2];
    logic        oe_w      [2];
    logic        busy_w    [2];
    logic        done_w    [2];
    logic        ackerr_w  [2];

    logic        pull      [2];
    logic        prev_scl  [2];
    logic        prev_pin  [2];
    logic [7:0]  shreg     [2];
    int          rise_cnt  [2];
    int          start_edges [2];
    int          stop_edges  [2];
    int          ack_seen  [2];
    bit          nack_first;

    logic [7:0]  exp_q[$];
    int          compared;
    int          mismatched;

    i2c_write_master #(.CLK_DIV(4), .NUM_BYTES(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_w[0]), .dev_addr(dev_addr),
        .data(data_v[15:0]), .sda_in(sda_in_w[0]), .scl(scl_w[0]),
        .sda_oe(oe_w[0]), .busy(busy_w[0]), .done(done_w[0]), .ack_err(ackerr_w[0])
    );

    i2c_write_master #(.CLK_DIV(1), .NUM_BYTES(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_w[1]), .dev_addr(dev_addr),
        .data(data_v), .sda_in(sda_in_w[1]), .scl(scl_w[1]),
        .sda_oe(oe_w[1]), .busy(busy_w[1]), .done(done_w[1]), .ack_err(ackerr_w[1])
    );

    assign sda_in_w[0] = ~(oe_w[0] | pull[0]);
    assign sda_in_w[1] = ~(oe_w[1] | pull[1]);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus monitor and slave: decodes bytes on SCL rises, pulls SDA in ACK slots,
    // counts SDA edges while SCL is high (must be exactly one START and one STOP).
    always @(negedge clk) begin : monitor
        logic pin_now;
        int   pos;
        logic [7:0] exp_b;
        for (int i = 0; i < 2; i++) begin
            pin_now = ~(oe_w[i] | pull[i]);
            if (reset) begin
                pull[i] = 1'b0;
            end else begin
                if (prev_scl[i] && scl_w[i] && pin_now != prev_pin[i]) begin
                    if (!pin_now) begin
                        start_edges[i]++;
                        rise_cnt[i] = 0;
                    end else begin
                        stop_edges[i]++;
                    end
                end
                if (!prev_scl[i] && scl_w[i]) begin
                    pos = rise_cnt[i] % 9;
                    if (pos < 8) shreg[i] = {shreg[i][6:0], pin_now};
                    if (pos == 7) begin
                        compared++;
                        if (exp_q.size() == 0) begin
                            mismatched++;
                            $display("FAIL byte_extra dut%0d: got %02h, expected no byte", i, shreg[i]);
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (shreg[i] !== exp_b) begin
                                mismatched++;
                                $display("FAIL byte_value dut%0d: got %02h, expected %02h", i, shreg[i], exp_b);
                            end
                        end
                    end
                    if (pos == 8) ack_seen[i]++;
                    rise_cnt[i]++;
                end
                if (prev_scl[i] && !scl_w[i])
                    pull[i] = (rise_cnt[i] % 9 == 8) && !(nack_first && rise_cnt[i] == 8);
            end
            prev_scl[i] = scl_w[i];
            prev_pin[i] = pin_now;
        end
    end

    task automatic clear_bus(input int idx);
        start_edges[idx] = 0;
        stop_edges[idx]  = 0;
        ack_seen[idx]    = 0;
    endtask

    task automatic run_txn(input int idx, input logic [6:0] a, input logic [23:0] d,
                           input bit nack, input int restart_at, input string name);
        int  nb;
        int  cd;
        int  exp_cycles;
        int  n;
        bit  got;
        nb = (idx == 1) ? 3 : 2;
        cd = (idx == 1) ? 1 : 4;
        exp_cycles = nack ? 11 * 4 * cd : (2 + 9 * (nb + 1)) * 4 * cd;
        exp_q.push_back({a, 1'b0});
        if (!nack)
            for (int b = 0; b < nb; b++) exp_q.push_back(d[8*(nb-b)-1 -: 8]);
        nack_first = nack;
        clear_bus(idx);

        @(negedge clk);
        dev_addr     = a;
        data_v       = d;
        start_w[idx] = 1'b1;
        @(negedge clk);
        start_w[idx] = 1'b0;

        compared++;
        if (busy_w[idx] !== 1'b1 || ackerr_w[idx] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_accept: busy=%b ack_err=%b, expected busy=1 ack_err=0", name, busy_w[idx], ackerr_w[idx]);
        end

        n   = 0;
        got = 1'b0;
        while (n < 4000 && !got) begin
            if (done_w[idx] === 1'b1) begin
                got = 1'b1;
            end else begin
                if (n == restart_at) begin
                    start_w[idx] = 1'b1;
                    dev_addr     = a ^ 7'h7f;
                    data_v       = ~d;
                end else begin
                    start_w[idx] = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        start_w[idx] = 1'b0;

        compared++;
        if (!got || n != exp_cycles) begin
            mismatched++;
            $display("FAIL %s_latency: done after %0d clocks (seen=%b), expected %0d", name, n, got, exp_cycles);
        end
        compared++;
        if (busy_w[idx] !== 1'b0 || ackerr_w[idx] !== nack) begin
            mismatched++;
            $display("FAIL %s_end_flags: busy=%b ack_err=%b, expected busy=0 ack_err=%b", name, busy_w[idx], ackerr_w[idx], nack);
        end
        @(negedge clk);
        compared++;
        if (done_w[idx] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_done_pulse: done=%b one clock later, expected 0", name, done_w[idx]);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_bytes: %0d expected bytes never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        compared++;
        if (start_edges[idx] != 1 || stop_edges[idx] != 1) begin
            mismatched++;
            $display("FAIL %s_protocol: start_edges=%0d stop_edges=%0d, expected 1 and 1", name, start_edges[idx], stop_edges[idx]);
        end
        compared++;
        if (ack_seen[idx] != (nack ? 1 : nb + 1)) begin
            mismatched++;
            $display("FAIL %s_ack_slots: got %0d, expected %0d", name, ack_seen[idx], nack ? 1 : nb + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        start_w[0] = 1'b1;
        start_w[1] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({scl_w[i], oe_w[i], busy_w[i], done_w[i], ackerr_w[i]} !== 5'b10000) begin
                mismatched++;
                $display("FAIL reset_outputs dut%0d: scl,oe,busy,done,ack_err=%b%b%b%b%b, expected 10000",
                         i, scl_w[i], oe_w[i], busy_w[i], done_w[i], ackerr_w[i]);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (busy_w[i] !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_wins dut%0d: busy=%b after start with reset, expected 0", i, busy_w[i]);
            end
        end
    endtask

    task automatic test_basic();
        run_txn(0, 7'h1A, 24'h001E00, 1'b0, -1, "basic");
    endtask

    task automatic test_nack();
        run_txn(0, 7'h55, 24'h00A5C3, 1'b1, -1, "nack");
        repeat (10) @(negedge clk);
        compared++;
        if (ackerr_w[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL nack_hold: ack_err=%b while idle, expected 1", ackerr_w[0]);
        end
    endtask

    task automatic test_busy_ignore();
        run_txn(0, 7'h3C, 24'h00F00F, 1'b0, 100, "busy_ignore");
    endtask

    task automatic test_reset_mid_data();
        bit saw_done;
        exp_q.push_back({7'h2B, 1'b0});
        nack_first = 1'b0;
        @(negedge clk);
        dev_addr   = 7'h2B;
        data_v     = 24'h00C3A5;
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({scl_w[0], oe_w[0], busy_w[0], done_w[0]} !== 4'b1000) begin
            mismatched++;
            $display("FAIL mid_reset_outputs: scl,oe,busy,done=%b%b%b%b, expected 1000",
                     scl_w[0], oe_w[0], busy_w[0], done_w[0]);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL mid_reset_addr: %0d bytes unseen, expected 0", exp_q.size());
            exp_q.delete();
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) saw_done = 1'b1;
        end
        compared++;
        if (saw_done) begin
            mismatched++;
            $display("FAIL mid_reset_quiet: done/busy activity=1 after reset, expected 0");
        end
        run_txn(0, 7'h21, {8'h00, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))}, 1'b0, -1, "after_reset");
    endtask

    task automatic test_div1_three_bytes();
        run_txn(1, 7'h1A, 24'hABCDEF, 1'b0, -1, "div1_fixed");
        for (int k = 0; k < 3; k++)
            run_txn(1, 7'($urandom_range(0, 127)), 24'($urandom_range(0, 24'hFFFFFF)), 1'b0, -1, "div1_rand");
        run_txn(1, 7'h7F, 24'h000000, 1'b1, -1, "div1_nack");
    endtask

    task automatic test_back_to_back();
        run_txn(0, 7'h00, 24'h00FFFF, 1'b0, -1, "b2b_a");
        run_txn(0, 7'h7F, 24'h000001, 1'b0, -1, "b2b_b");
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        start_w[0]  = 1'b0;
        start_w[1]  = 1'b0;
        dev_addr    = '0;
        data_v      = '0;
        nack_first  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pull[i]        = 1'b0;
            prev_scl[i]    = 1'b1;
            prev_pin[i]    = 1'b1;
            shreg[i]       = '0;
            rise_cnt[i]    = 0;
            start_edges[i] = 0;
            stop_edges[i]  = 0;
            ack_seen[i]    = 0;
        end

        test_reset();
        test_basic();
        test_nack();
        test_busy_ignore();
        test_reset_mid_data();
        test_div1_three_bytes();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Parametrised I2C write-only master, successor to the fixed open-loop codec-config transmitter.
- Generates SCL from the system clock via a programmable divider.
- Sends START, 7-bit address + W, NUM_BYTES data bytes (each with ACK check), then STOP.
- Drives SDA open-drain style. Sits between the config sequencer (start/busy/done handshake) and the board I2C pins.

Parameters:
- CLK_DIV, 4, system clocks per SCL quarter-period (>=1); one bit slot = 4*CLK_DIV clocks.
- NUM_BYTES, 2, data bytes sent per transaction (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-high
- start  input  1  one-cycle request; accepted only when busy=0
- dev_addr  input  7  slave address, latched on accepted start
- data  input  8*NUM_BYTES  payload, latched on accepted start; byte 0 = data[8*NUM_BYTES-1 -: 8], sent first, MSB first
- sda_in  input  1  sampled SDA pin level
- scl  output  1  SCL level (push-pull)
- sda_oe  output  1  1 = pull SDA low, 0 = release (pin reads high)
- busy  output  1  high from the cycle after an accepted start until the done pulse
- done  output  1  one-cycle pulse when STOP completes
- ack_err  output  1  set on any NACK; holds until next accepted start or reset

Behaviour:
- Reset, including mid-transaction, forces the following in the next cycle:
  - scl=1, sda_oe=0, busy=0, done=0, ack_err=0
  - state IDLE; all counters cleared.
- Timing base:
  - Quarter counter runs 0..CLK_DIV-1, then advances quarter q 0..3.
  - Bit-slot boundary occurs when q=3 and the counter ends.
  - Timing registers are held at zero in IDLE.
- States: IDLE, START, ADDR, ACK, DATA, STOP.
- IDLE:
  - scl=1, sda_oe=0.
  - start=1 latches dev_addr, data; clears ack_err; sets busy; moves to START. Latency start -> busy = 1 clock.
- START (1 slot):
  - q0-q1: scl=1, SDA released.
  - q2-q3: scl=1, SDA low.
  - Then ADDR.
- ADDR (8 slots):
  - Shifts {dev_addr, 1'b0} MSB first.
  - Per slot, q0-q1 scl=0, q2-q3 scl=1.
  - sda_oe = ~bit, updated only at the start of q0 (SCL low).
- ACK (1 slot):
  - Same scl pattern, sda_oe=0.
  - sda_in sampled at the last clock of q2.
  - 1 = NACK: set ack_err, go to STOP.
  - 0 = ACK: go to DATA if bytes remain, else STOP.
- DATA (8 slots per byte):
  - Same bit timing as ADDR; byte index increments after each ACK.
  - Byte counter width = clog2(NUM_BYTES+1).
- STOP (1 slot):
  - q0: scl=0, SDA low.
  - q1: scl=1, SDA low.
  - q2-q3: scl=1, SDA released.
  - At slot end: IDLE, done=1 for one clock, busy=0 in the same clock.
- SDA never changes while scl=1 except the START/STOP edges.
- start while busy=1 is ignored; latched data cannot change mid-transaction.
- start coincident with reset: reset wins.
- Full transaction length = (2 + 9*(NUM_BYTES+1)) * 4*CLK_DIV clocks from the first START clock to the done pulse. Defaults: 29 slots = 464 clocks.
- NACK on the address aborts with STOP immediately; no data bytes are sent.

Test Plan:
- Defaults, dev_addr=7'h1A, data=16'h1E00, slave ACKs all:
  - SDA sequence on SCL rising edges: 0x34, 0x1E, 0x00 with ACK gaps.
  - done at clock 464 after START entry; ack_err=0.
- Slave NACKs the address (sda_in=1 in the first ACK slot):
  - STOP follows directly; no DATA slots.
  - done after 11 slots (176 clocks); ack_err=1 until next start.
- start pulsed again while busy:
  - Ignored; transaction and latched data unchanged.
  - Next start after done is accepted and clears ack_err.
- reset asserted mid-DATA:
  - Next clock scl=1, sda_oe=0, busy=0, no done pulse.
  - Later start completes a normal transaction.
- CLK_DIV=1, NUM_BYTES=3:
  - Slot = 4 clocks; total 38 slots = 152 clocks.
  - 3 data bytes plus 4 ACK checks observed.
- Protocol checker over all runs:
  - SDA stable while SCL high except exactly one START and one STOP edge per transaction.
